// File: rtl/line_buf_pkg.sv
// Shared constants and helpers for the sliding-window line buffer.
package line_buf_pkg;
    localparam int INTEGER_BITS     = 8;
    localparam int FIXED_POINT_BITS = 4;
    localparam int DEFAULT_DATA_W   = INTEGER_BITS + FIXED_POINT_BITS;

    // Bits needed to index 'value' distinct items; never less than 1.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction
endpackage

// File: rtl/window_line_buffer_if.sv
// Sample-in / window-out bundle of the line buffer.
// Handshake: a transfer happens on a cycle where both valid and ready are high;
// ready may depend on registered state only, and an offer without ready is dropped.
interface window_line_buffer_if #(
    parameter int DATA_W    = line_buf_pkg::DEFAULT_DATA_W,
    parameter int KERNEL    = 3,
    parameter int NUM_LINES = 4
);
    localparam int CNT_W = line_buf_pkg::clog2(NUM_LINES + 1);

    logic [DATA_W-1:0]               i_data;
    logic                            i_data_valid;
    logic                            o_in_ready;
    logic [DATA_W*KERNEL*KERNEL-1:0] o_win_data;
    logic                            o_win_valid;
    logic                            i_win_ready;
    logic [CNT_W-1:0]                o_line_cnt;

    modport master (
        output i_data, i_data_valid, i_win_ready,
        input  o_in_ready, o_win_data, o_win_valid, o_line_cnt
    );

    modport slave (
        input  i_data, i_data_valid, i_win_ready,
        output o_in_ready, o_win_data, o_win_valid, o_line_cnt
    );
endinterface

// File: rtl/line_store.sv
// One line of samples: single write port, KERNEL adjacent combinational read taps.
module line_store import line_buf_pkg::*; #(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int LINE_W = 512,
    parameter int KERNEL = 3,
    localparam int COL_W = clog2(LINE_W)
) (
    input  logic                     i_clk,
    input  logic                     i_wr_en,
    input  logic [COL_W-1:0]         i_wr_col,
    input  logic [DATA_W-1:0]        i_wr_data,
    input  logic [COL_W-1:0]         i_rd_col,
    output logic [KERNEL*DATA_W-1:0] o_taps
);
    logic [DATA_W-1:0] mem_q [LINE_W];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            mem_q[i_wr_col] <= i_wr_data;
        end
    end

    // Tap 0 (column rd_col) sits at the MSB end.
    always_comb begin
        o_taps = '0;
        for (int k = 0; k < KERNEL; k++) begin
            o_taps[(KERNEL-1-k)*DATA_W +: DATA_W] = mem_q[i_rd_col + COL_W'(k)];
        end
    end
endmodule

// File: rtl/window_line_buffer.sv
// Ring of line stores presenting a KERNEL x KERNEL window that slides along the oldest lines.
module window_line_buffer import line_buf_pkg::*; #(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int LINE_W    = 512,
    parameter int NUM_LINES = 4,
    parameter int KERNEL    = 3
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_clear,
    window_line_buffer_if.slave  bus
);
    localparam int COL_W = clog2(LINE_W);
    localparam int LN_W  = clog2(NUM_LINES);
    localparam int CNT_W = clog2(NUM_LINES + 1);
    localparam int ROW_W = KERNEL * DATA_W;

    logic [COL_W-1:0] wr_col_q, wr_col_d, rd_col_q, rd_col_d;
    logic [LN_W-1:0]  wr_line_q, wr_line_d, rd_line_q, rd_line_d;
    logic [CNT_W-1:0] line_cnt_q, line_cnt_d;
    logic             in_ready, win_valid, wr_fire, pop_fire, line_done, line_retire;
    logic [ROW_W-1:0] taps [NUM_LINES];
    logic [DATA_W*KERNEL*KERNEL-1:0] win_data;

    function automatic int row_line(input int base, input int r);
        int s;
        s = base + r;
        return (s >= NUM_LINES) ? s - NUM_LINES : s;
    endfunction

    assign in_ready    = line_cnt_q < CNT_W'(NUM_LINES);
    assign win_valid   = line_cnt_q >= CNT_W'(KERNEL);
    assign wr_fire     = bus.i_data_valid && in_ready && !i_clear;
    assign pop_fire    = win_valid && bus.i_win_ready && !i_clear;
    assign line_done   = wr_fire && (wr_col_q == COL_W'(LINE_W - 1));
    assign line_retire = pop_fire && (rd_col_q == COL_W'(LINE_W - KERNEL));

    always_comb begin
        wr_col_d   = wr_col_q;
        wr_line_d  = wr_line_q;
        rd_col_d   = rd_col_q;
        rd_line_d  = rd_line_q;
        line_cnt_d = line_cnt_q;
        if (i_clear) begin
            wr_col_d   = '0;
            wr_line_d  = '0;
            rd_col_d   = '0;
            rd_line_d  = '0;
            line_cnt_d = '0;
        end else begin
            if (line_done) begin
                wr_col_d  = '0;
                wr_line_d = (wr_line_q == LN_W'(NUM_LINES - 1)) ? '0 : wr_line_q + LN_W'(1);
            end else if (wr_fire) begin
                wr_col_d = wr_col_q + COL_W'(1);
            end
            if (line_retire) begin
                rd_col_d  = '0;
                rd_line_d = (rd_line_q == LN_W'(NUM_LINES - 1)) ? '0 : rd_line_q + LN_W'(1);
            end else if (pop_fire) begin
                rd_col_d = rd_col_q + COL_W'(1);
            end
            case ({line_done, line_retire})
                2'b10:   line_cnt_d = line_cnt_q + CNT_W'(1);
                2'b01:   line_cnt_d = line_cnt_q - CNT_W'(1);
                default: line_cnt_d = line_cnt_q;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_col_q   <= '0;
            wr_line_q  <= '0;
            rd_col_q   <= '0;
            rd_line_q  <= '0;
            line_cnt_q <= '0;
        end else begin
            wr_col_q   <= wr_col_d;
            wr_line_q  <= wr_line_d;
            rd_col_q   <= rd_col_d;
            rd_line_q  <= rd_line_d;
            line_cnt_q <= line_cnt_d;
        end
    end

    for (genvar l = 0; l < NUM_LINES; l++) begin : g_line
        line_store #(
            .DATA_W (DATA_W),
            .LINE_W (LINE_W),
            .KERNEL (KERNEL)
        ) u_line_store (
            .i_clk     (i_clk),
            .i_wr_en   (wr_fire && i_rst_n && (wr_line_q == LN_W'(l))),
            .i_wr_col  (wr_col_q),
            .i_wr_data (bus.i_data),
            .i_rd_col  (rd_col_q),
            .o_taps    (taps[l])
        );
    end

    // Row 0 is the oldest line and occupies the top bits of the window.
    always_comb begin
        win_data = '0;
        for (int r = 0; r < KERNEL; r++) begin
            win_data[(KERNEL-1-r)*ROW_W +: ROW_W] = taps[LN_W'(row_line(int'(rd_line_q), r))];
        end
    end

    assign bus.o_in_ready  = in_ready;
    assign bus.o_win_valid = win_valid;
    assign bus.o_win_data  = win_data;
    assign bus.o_line_cnt  = line_cnt_q;
endmodule

// File: tb/tb_window_line_buffer.sv
// Bench for window_line_buffer: directed scenarios plus random traffic against a queue-based model.
module tb_window_line_buffer;
    localparam int DATA_W    = 12;
    localparam int LINE_W    = 8;
    localparam int NUM_LINES = 4;
    localparam int KERNEL    = 3;
    localparam int WIN_W     = DATA_W * KERNEL * KERNEL;

    logic i_clk = 1'b0;
    logic i_rst_n;
    logic i_clear;

    window_line_buffer_if #(.DATA_W(DATA_W), .KERNEL(KERNEL), .NUM_LINES(NUM_LINES)) bus ();

    window_line_buffer #(
        .DATA_W    (DATA_W),
        .LINE_W    (LINE_W),
        .NUM_LINES (NUM_LINES),
        .KERNEL    (KERNEL)
    ) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clear (i_clear),
        .bus     (bus)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    // Model: completed lines held as one flat sample queue, plus the line under construction.
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] cur_q[$];
    int rd_col = 0;
    int wl = 0;
    int wcol = 0;
    int lines_done = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [WIN_W-1:0] model_window();
        logic [WIN_W-1:0] w;
        w = '0;
        for (int r = 0; r < KERNEL; r++) begin
            for (int c = 0; c < KERNEL; c++) begin
                w[((KERNEL-1-r)*KERNEL + (KERNEL-1-c))*DATA_W +: DATA_W] = exp_q[r*LINE_W + rd_col + c];
            end
        end
        return w;
    endfunction

    task automatic check_outputs();
        int lines;
        lines = exp_q.size() / LINE_W;
        check_eq("in_ready", 128'(bus.o_in_ready), 128'(lines < NUM_LINES));
        check_eq("win_valid", 128'(bus.o_win_valid), 128'(lines >= KERNEL));
        check_eq("line_cnt", 128'(bus.o_line_cnt), 128'(lines));
        if (lines >= KERNEL) begin
            check_eq("win_data", 128'(bus.o_win_data), 128'(model_window()));
        end
    endtask

    // One clock: apply inputs, check outputs mid-cycle, then advance the model.
    task automatic step(input bit dv, input bit wrdy, input bit clr, input bit rstn);
        int lines;
        bit acc;
        bit pop;
        logic [DATA_W-1:0] data;
        data = DATA_W'(16 * (wl % 256) + wcol);
        bus.i_data       = data;
        bus.i_data_valid = dv;
        bus.i_win_ready  = wrdy;
        i_clear          = clr;
        i_rst_n          = rstn;
        #2;
        check_outputs();
        lines = exp_q.size() / LINE_W;
        acc = dv && (lines < NUM_LINES);
        pop = wrdy && (lines >= KERNEL);
        @(posedge i_clk);
        #1;
        if (!rstn || clr) begin
            exp_q.delete();
            cur_q.delete();
            rd_col = 0;
            wl = 0;
            wcol = 0;
        end else begin
            if (pop) begin
                if (rd_col == LINE_W - KERNEL) begin
                    rd_col = 0;
                    repeat (LINE_W) void'(exp_q.pop_front());
                end else begin
                    rd_col++;
                end
            end
            if (acc) begin
                cur_q.push_back(data);
                wcol++;
                if (cur_q.size() == LINE_W) begin
                    foreach (cur_q[i]) exp_q.push_back(cur_q[i]);
                    cur_q.delete();
                    wcol = 0;
                    wl++;
                    lines_done++;
                end
            end
        end
    endtask

    initial begin
        logic [WIN_W-1:0] first_win;
        int cycles;
        i_rst_n = 1'b0;
        i_clear = 1'b0;
        bus.i_data = '0;
        bus.i_data_valid = 1'b0;
        bus.i_win_ready = 1'b0;
        @(posedge i_clk);
        #1;

        // Reset state, then three full lines
        repeat (2) step(0, 0, 0, 0);
        repeat (3 * LINE_W) step(1, 0, 0, 1);
        first_win = '0;
        for (int r = 0; r < KERNEL; r++)
            for (int c = 0; c < KERNEL; c++)
                first_win[((KERNEL-1-r)*KERNEL + (KERNEL-1-c))*DATA_W +: DATA_W] = DATA_W'(16*r + c);
        #2;
        check_eq("first_win", 128'(bus.o_win_data), 128'(first_win));
        check_eq("first_cnt", 128'(bus.o_line_cnt), 128'(3));

        // Six pops walk the window to the line end and retire line 0
        repeat (6) step(0, 1, 0, 1);
        #2;
        check_eq("cnt_after_pops", 128'(bus.o_line_cnt), 128'(2));
        check_eq("valid_after_pops", 128'(bus.o_win_valid), 128'(0));

        // Fill all four stores, offer a 33rd sample, then free a line
        step(0, 0, 1, 1);
        repeat (4 * LINE_W) step(1, 0, 0, 1);
        repeat (3) step(1, 0, 0, 1);
        #2;
        check_eq("full_ready", 128'(bus.o_in_ready), 128'(0));
        repeat (6) step(1, 1, 0, 1);
        step(1, 0, 0, 1);

        // Align line completion with retirement so the count holds steady across wraps
        step(0, 0, 1, 1);
        repeat (3 * LINE_W) step(1, 0, 0, 1);
        repeat (4) begin
            repeat (2) step(1, 0, 0, 1);
            repeat (6) step(1, 1, 0, 1);
            #2;
            check_eq("aligned_cnt", 128'(bus.o_line_cnt), 128'(3));
        end

        // Reset in the middle of a line
        step(0, 0, 1, 1);
        repeat (5) step(1, 0, 0, 1);
        step(1, 1, 0, 0);
        #2;
        check_eq("rst_cnt", 128'(bus.o_line_cnt), 128'(0));
        check_eq("rst_valid", 128'(bus.o_win_valid), 128'(0));
        repeat (3 * LINE_W) step(1, 0, 0, 1);
        #2;
        check_eq("rst_first_sample", 128'(bus.o_win_data[WIN_W-1 -: DATA_W]), 128'(0));

        // Clear with a simultaneous write and pop discards both
        step(1, 1, 1, 1);

        // Random traffic over at least 20 lines
        lines_done = 0;
        cycles = 0;
        while (lines_done < 20 && cycles < 4000) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 199) == 0, 1'b1);
            cycles++;
        end
        check_eq("rand_lines_done", 128'(lines_done >= 20), 128'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
